pc_branch_unit: RTL

- Program-counter stage directly downstream of the conditional-branch flag logic in the Mini SRC datapath.
- Evaluates the branch condition from IR[20:19] against the bus contents and latches the result as con_q.
- On a branch request, computes target = PC + sign-extended IR[18:0] and commits it only when con_q is set.
- Also handles PC load from the bus and the fetch increment.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/pc_branch_unit_if.sv | 57 +++++
 rtl/br_cond_eval.sv | 27 ++
 rtl/pc_branch_unit.sv | 115 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the Mini SRC program-counter and branch logic.
//   - Branch-condition codes carried in IR[20:19].
//   - Field positions of the condition code inside IR.
//   - Branch sequencer state encoding (IDLE -> CALC -> COMMIT).
package cpu_pkg;

  // Branch-condition codes (IR[IR_C2_HI:IR_C2_LO]).
  localparam logic [1:0] BR_ZR = 2'b00;  // branch if register == 0
  localparam logic [1:0] BR_NZ = 2'b01;  // branch if register != 0
  localparam logic [1:0] BR_PL = 2'b10;  // branch if register >= 0 (sign clear)
  localparam logic [1:0] BR_MI = 2'b11;  // branch if register <  0 (sign set)

  // Position of the condition code inside the instruction register.
  localparam int IR_C2_HI = 20;
  localparam int IR_C2_LO = 19;

  // Branch sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } br_state_e;

endpackage

// File: rtl/pc_branch_unit_if.sv
// pc_branch_unit_if: groups the datapath-facing signals of pc_branch_unit.
//   master modport : the control unit / datapath side that drives requests.
//   slave modport  : pc_branch_unit itself.
// Signals:
//   ir, bus_in       instruction register and bus contents (condition operand)
//   con_in           latch the evaluated condition into con_q
//   pc_in, pc_inc    load PC from bus_in / increment PC
//   br_go            single-cycle strobe starting a branch sequence
//   pc_out, con_q    current PC and latched condition
//   br_busy          sequence in progress
//   br_done          one-cycle completion pulse; br_taken is valid with it
//   br_state         sequencer state, exported for observation
//   br_taken_cnt,    taken / not-taken counters, present only when
//   br_nottaken_cnt  PC_BRANCH_STATS_EN is defined
//
// Handshake: br_go is sampled only while br_busy is low; a sampled br_go
// raises br_busy on the next cycle, and exactly one br_done pulse (with
// br_taken) follows for that request. br_go while br_busy is high is ignored.
interface pc_branch_unit_if #(
  parameter int WIDTH = 32
);
  import cpu_pkg::*;

  logic [WIDTH-1:0] ir;
  logic [WIDTH-1:0] bus_in;
  logic             con_in;
  logic             pc_in;
  logic             pc_inc;
  logic             br_go;
  logic [WIDTH-1:0] pc_out;
  logic             con_q;
  logic             br_busy;
  logic             br_done;
  logic             br_taken;
  br_state_e        br_state;
`ifdef PC_BRANCH_STATS_EN
  logic [15:0]      br_taken_cnt;
  logic [15:0]      br_nottaken_cnt;
`endif

  modport master (
    output ir, bus_in, con_in, pc_in, pc_inc, br_go,
    input  pc_out, con_q, br_busy, br_done, br_taken, br_state
`ifdef PC_BRANCH_STATS_EN
    , input br_taken_cnt, br_nottaken_cnt
`endif
  );

  modport slave (
    input  ir, bus_in, con_in, pc_in, pc_inc, br_go,
    output pc_out, con_q, br_busy, br_done, br_taken, br_state
`ifdef PC_BRANCH_STATS_EN
    , output br_taken_cnt, br_nottaken_cnt
`endif
  );

endinterface

// File: rtl/br_cond_eval.sv
// br_cond_eval: combinational branch-condition evaluation.
//   c2    in  2      condition code from IR[20:19]
//   value in  WIDTH  register value under test (bus contents)
//   cond  out 1      1 when the condition holds
// Kept separate so the control unit can reuse the same decode.
module br_cond_eval
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       c2,
  input  logic [WIDTH-1:0] value,
  output logic             cond
);

  always_comb begin
    cond = 1'b0;
    case (c2)
      BR_ZR:   cond = (value == '0);
      BR_NZ:   cond = (value != '0);
      BR_PL:   cond = ~value[WIDTH-1];
      BR_MI:   cond = value[WIDTH-1];
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: Mini SRC program counter with conditional-branch sequencer.
//   clk  system clock, rising edge
//   clr  asynchronous active-high reset
//   bif  pc_branch_unit_if.slave (ir, bus_in, con_in, pc_in, pc_inc, br_go in;
//        pc_out, con_q, br_busy, br_done, br_taken, br_state out)
// Branch sequence: IDLE --br_go--> CALC (target = PC + sext(C)) --> COMMIT
// (PC <= target when con_q) --> IDLE. br_done/br_taken are high during COMMIT.
// PC write priority per cycle: pc_in > taken COMMIT redirect > pc_inc.
// Optional: define PC_BRANCH_STATS_EN to add saturating 16-bit taken /
// not-taken counters (br_taken_cnt, br_nottaken_cnt on the interface).
module pc_branch_unit
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               OFFSET_W = 19,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              clr,
  pc_branch_unit_if.slave   bif
);

  br_state_e        state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] target_q;
  logic             con_q;
  logic             done_q;
  logic             taken_q;
  logic             cond;
  logic             con_next;
  logic             redirect;
  logic [WIDTH-1:0] offset_sext;
  logic             unused_ir_bits;
`ifdef PC_BRANCH_STATS_EN
  logic [15:0]      taken_cnt_q;
  logic [15:0]      nottaken_cnt_q;
`endif

  br_cond_eval #(.WIDTH(WIDTH)) u_cond (
    .c2    (bif.ir[IR_C2_HI:IR_C2_LO]),
    .value (bif.bus_in),
    .cond  (cond)
  );

  assign offset_sext    = {{(WIDTH-OFFSET_W){bif.ir[OFFSET_W-1]}}, bif.ir[OFFSET_W-1:0]};
  assign unused_ir_bits = ^bif.ir[WIDTH-1:IR_C2_HI+1];

  // Value con_q will hold after this edge; COMMIT must see a con_in issued
  // during CALC, so br_taken is registered from this rather than from con_q.
  assign con_next = bif.con_in ? cond : con_q;
  assign redirect = (state_q == COMMIT) && con_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      target_q <= '0;
      con_q    <= 1'b0;
      done_q   <= 1'b0;
      taken_q  <= 1'b0;
`ifdef PC_BRANCH_STATS_EN
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
`endif
    end else begin
      con_q   <= con_next;
      done_q  <= 1'b0;
      taken_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bif.br_go) state_q <= CALC;
        end
        CALC: begin
          target_q <= pc_q + offset_sext;
          state_q  <= COMMIT;
          // Registered completion flags land in the COMMIT cycle.
          done_q   <= 1'b1;
          taken_q  <= con_next;
        end
        COMMIT: begin
          state_q <= IDLE;
`ifdef PC_BRANCH_STATS_EN
          if (con_q) begin
            if (taken_cnt_q != 16'hFFFF) taken_cnt_q <= taken_cnt_q + 16'd1;
          end else begin
            if (nottaken_cnt_q != 16'hFFFF) nottaken_cnt_q <= nottaken_cnt_q + 16'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase

      // Lower-priority PC requests are dropped, not queued.
      if (bif.pc_in)
        pc_q <= bif.bus_in;
      else if (redirect)
        pc_q <= target_q;
      else if (bif.pc_inc)
        pc_q <= pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign bif.pc_out   = pc_q;
  assign bif.con_q    = con_q;
  assign bif.br_busy  = (state_q != IDLE);
  assign bif.br_done  = done_q;
  assign bif.br_taken = taken_q;
  assign bif.br_state = state_q;
`ifdef PC_BRANCH_STATS_EN
  assign bif.br_taken_cnt    = taken_cnt_q;
  assign bif.br_nottaken_cnt = nottaken_cnt_q;
`endif

endmodule
